// File: rtl/dual_port_queue.sv
// Two-wide circular queue: up to two pushes and two pops per cycle. It also
// supports tail rollback, a random-access probe port and an almost-full flag.
module dual_port_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_IN,
  input  logic [1:0]            pushCnt_IN,
  input  logic [DATA_WIDTH-1:0] data0_IN,
  input  logic [DATA_WIDTH-1:0] data1_IN,
  input  logic [1:0]            popCnt_IN,
  output logic [DATA_WIDTH-1:0] data0_OUT,
  output logic [DATA_WIDTH-1:0] data1_OUT,
  output logic                  valid0_OUT,
  output logic                  valid1_OUT,
  output logic                  pushAccept_OUT,
  output logic                  popAccept_OUT,
  output logic [ADDR_WIDTH:0]   count_OUT,
  output logic                  emptyFlag_OUT,
  output logic                  fullFlag_OUT,
  output logic                  almostFull_OUT,
  output logic [ADDR_WIDTH-1:0] curHead_OUT,
  output logic [ADDR_WIDTH-1:0] curTail_OUT,
  input  logic                  rollback_IN,
  input  logic [ADDR_WIDTH-1:0] rollbackTail_IN,
  output logic                  rollbackErr_OUT,
  input  logic [ADDR_WIDTH-1:0] probeIdx_IN,
  output logic [DATA_WIDTH-1:0] probeData_OUT,
  input  logic                  probeWe_IN,
  input  logic [DATA_WIDTH-1:0] probeData_IN
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [31:0] AF_C = AF_MARGIN;

  logic [DATA_WIDTH-1:0] buffer [DEPTH];
  logic [ADDR_WIDTH-1:0] head, tail, headPlus1, tailPlus1, rbDist;
  logic [ADDR_WIDTH:0]   count, freeSlots;
  logic [1:0]            pushReq, popReq, pushAmt, popAmt;
  logic                  rollbackErr, rbValid;

  // Handshake: pushAccept_OUT/popAccept_OUT act as ready for the request held on
  // pushCnt_IN/popCnt_IN (1 or 2 = valid). The transfer happens at the clock edge
  // of a cycle where both are high, and it moves either the whole count or nothing.
  assign pushReq   = (pushCnt_IN == 2'd3) ? 2'd0 : pushCnt_IN;
  assign popReq    = (popCnt_IN == 2'd3) ? 2'd0 : popCnt_IN;
  assign freeSlots = DEPTH_C - count;
  assign headPlus1 = head + 1'b1;
  assign tailPlus1 = tail + 1'b1;

  assign pushAccept_OUT = (pushReq != 2'd0) && !flush_IN && !rollback_IN &&
                          (freeSlots >= {{(ADDR_WIDTH-1){1'b0}}, pushReq});
  assign popAccept_OUT  = (popReq != 2'd0) && !flush_IN && !rollback_IN &&
                          (count >= {{(ADDR_WIDTH-1){1'b0}}, popReq});
  assign pushAmt = pushAccept_OUT ? pushReq : 2'd0;
  assign popAmt  = popAccept_OUT ? popReq : 2'd0;

  // A full queue rolled back to head gives distance 0, which empties it as intended.
  assign rbDist  = rollbackTail_IN - head;
  assign rbValid = ({1'b0, rbDist} <= count);

  always_ff @(posedge clk) begin
    if (!reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      rollbackErr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else begin
      rollbackErr <= 1'b0;
      if (flush_IN) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else if (rollback_IN) begin
        if (rbValid) begin
          tail  <= rollbackTail_IN;
          count <= {1'b0, rbDist};
        end else begin
          rollbackErr <= 1'b1;
        end
      end else begin
        if (pushAccept_OUT) begin
          buffer[tail] <= data0_IN;
          if (pushReq == 2'd2) buffer[tailPlus1] <= data1_IN;
        end
        tail  <= tail + ADDR_WIDTH'(pushAmt);
        head  <= head + ADDR_WIDTH'(popAmt);
        count <= count + (ADDR_WIDTH+1)'(pushAmt) - (ADDR_WIDTH+1)'(popAmt);
      end
      // Placed last so a probe write overrides a push to the same slot.
      if (probeWe_IN) buffer[probeIdx_IN] <= probeData_IN;
    end
  end

  assign data0_OUT       = buffer[head];
  assign data1_OUT       = buffer[headPlus1];
  assign probeData_OUT   = buffer[probeIdx_IN];
  assign valid0_OUT      = (count != '0);
  assign valid1_OUT      = (count >= (ADDR_WIDTH+1)'(2));
  assign count_OUT       = count;
  assign emptyFlag_OUT   = (count == '0);
  assign fullFlag_OUT    = (count == DEPTH_C);
  assign almostFull_OUT  = (32'(freeSlots) <= AF_C);
  assign curHead_OUT     = head;
  assign curTail_OUT     = tail;
  assign rollbackErr_OUT = rollbackErr;
endmodule

// File: tb/tb_dual_port_queue.sv
// Bench for dual_port_queue: directed vector table, hand-written corner sequences
// and random traffic, all compared against an array-based reference model.
module tb_dual_port_queue;
  logic        clk = 1'b0;
  logic        reset, flush_IN, rollback_IN, probeWe_IN;
  logic [1:0]  pushCnt_IN, popCnt_IN;
  logic [31:0] data0_IN, data1_IN, probeData_IN;
  logic [2:0]  rollbackTail_IN, probeIdx_IN;
  logic [31:0] data0_OUT, data1_OUT, probeData_OUT;
  logic        valid0_OUT, valid1_OUT, pushAccept_OUT, popAccept_OUT;
  logic        emptyFlag_OUT, fullFlag_OUT, almostFull_OUT, rollbackErr_OUT;
  logic [3:0]  count_OUT;
  logic [2:0]  curHead_OUT, curTail_OUT;

  dual_port_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .AF_MARGIN(2)) dut (
    .clk(clk), .reset(reset), .flush_IN(flush_IN), .pushCnt_IN(pushCnt_IN),
    .data0_IN(data0_IN), .data1_IN(data1_IN), .popCnt_IN(popCnt_IN),
    .data0_OUT(data0_OUT), .data1_OUT(data1_OUT), .valid0_OUT(valid0_OUT),
    .valid1_OUT(valid1_OUT), .pushAccept_OUT(pushAccept_OUT),
    .popAccept_OUT(popAccept_OUT), .count_OUT(count_OUT),
    .emptyFlag_OUT(emptyFlag_OUT), .fullFlag_OUT(fullFlag_OUT),
    .almostFull_OUT(almostFull_OUT), .curHead_OUT(curHead_OUT),
    .curTail_OUT(curTail_OUT), .rollback_IN(rollback_IN),
    .rollbackTail_IN(rollbackTail_IN), .rollbackErr_OUT(rollbackErr_OUT),
    .probeIdx_IN(probeIdx_IN), .probeData_OUT(probeData_OUT),
    .probeWe_IN(probeWe_IN), .probeData_IN(probeData_IN)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fl, rb, pwe;
    logic [1:0]  pc, oc;
    logic [31:0] d0, d1, pd;
    logic [2:0]  rbt, pidx;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [3:0]  cnt;
    logic [2:0]  h, t;
    logic        pa, oa, af, full;
    logic [31:0] d0, d1;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  // reference model: plain array, head index and occupancy
  logic [31:0] mem [8];
  int          mHead, mCnt;
  logic        mErr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.fl = 1'b0; s.rb = 1'b0; s.pwe = 1'b0;
    s.pc = 2'd0; s.oc = 2'd0; s.d0 = '0; s.d1 = '0; s.pd = '0;
    s.rbt = '0; s.pidx = '0;
    return s;
  endfunction

  function automatic stim_t op(input logic [1:0] pc, input logic [31:0] a, b,
                               input logic [1:0] oc);
    stim_t s = idle();
    s.pc = pc; s.d0 = a; s.d1 = b; s.oc = oc;
    return s;
  endfunction

  function automatic int pushN(input stim_t s);
    int n = (s.pc == 2'd3) ? 0 : int'(s.pc);
    if (n == 0 || s.fl || s.rb || (8 - mCnt) < n) return 0;
    return n;
  endfunction

  function automatic int popN(input stim_t s);
    int n = (s.oc == 2'd3) ? 0 : int'(s.oc);
    if (n == 0 || s.fl || s.rb || mCnt < n) return 0;
    return n;
  endfunction

  task automatic check_model(input stim_t s);
    chk("data0", data0_OUT, mem[mHead]);
    chk("data1", data1_OUT, mem[(mHead + 1) % 8]);
    chk("valid0", valid0_OUT, mCnt >= 1);
    chk("valid1", valid1_OUT, mCnt >= 2);
    chk("count", count_OUT, mCnt);
    chk("empty", emptyFlag_OUT, mCnt == 0);
    chk("full", fullFlag_OUT, mCnt == 8);
    chk("almostFull", almostFull_OUT, (8 - mCnt) <= 2);
    chk("head", curHead_OUT, mHead);
    chk("tail", curTail_OUT, (mHead + mCnt) % 8);
    chk("pushAccept", pushAccept_OUT, pushN(s) != 0);
    chk("popAccept", popAccept_OUT, popN(s) != 0);
    chk("rollbackErr", rollbackErr_OUT, mErr);
    chk("probeData", probeData_OUT, mem[s.pidx]);
  endtask

  task automatic model_step(input stim_t s);
    int pn, on, tl, d;
    logic err;
    if (!s.rst) begin
      for (int i = 0; i < 8; i++) mem[i] = '0;
      mHead = 0; mCnt = 0; mErr = 1'b0;
      return;
    end
    pn = pushN(s); on = popN(s); err = 1'b0;
    if (s.fl) begin
      mHead = 0; mCnt = 0;
    end else if (s.rb) begin
      d = (int'(s.rbt) - mHead + 8) % 8;
      if (d <= mCnt) mCnt = d;
      else err = 1'b1;
    end else begin
      tl = (mHead + mCnt) % 8;
      if (pn >= 1) mem[tl] = s.d0;
      if (pn == 2) mem[(tl + 1) % 8] = s.d1;
      mHead = (mHead + on) % 8;
      mCnt  = mCnt + pn - on;
    end
    if (s.pwe) mem[s.pidx] = s.pd;
    mErr = err;
  endtask

  // driver: apply one cycle of stimulus, check pre-edge outputs, then clock it in
  task automatic apply(input stim_t s);
    reset = s.rst; flush_IN = s.fl; rollback_IN = s.rb; rollbackTail_IN = s.rbt;
    pushCnt_IN = s.pc; data0_IN = s.d0; data1_IN = s.d1; popCnt_IN = s.oc;
    probeIdx_IN = s.pidx; probeWe_IN = s.pwe; probeData_IN = s.pd;
    #1;
    check_model(s);
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stim_t s = idle();
    s.rst = 1'b0;
    apply(s);
  endtask

  vec_t vecs [7];

  initial begin
    stim_t s;
    vecs[0] = '{op(2, 32'h10, 32'h11, 0), 4'd0, 3'd0, 3'd0, 1, 0, 0, 0, 32'h0,  32'h0};
    vecs[1] = '{op(2, 32'h12, 32'h13, 0), 4'd2, 3'd0, 3'd2, 1, 0, 0, 0, 32'h10, 32'h11};
    vecs[2] = '{op(2, 32'h14, 32'h15, 0), 4'd4, 3'd0, 3'd4, 1, 0, 0, 0, 32'h10, 32'h11};
    vecs[3] = '{op(2, 32'h16, 32'h17, 0), 4'd6, 3'd0, 3'd6, 1, 0, 1, 0, 32'h10, 32'h11};
    vecs[4] = '{op(1, 32'h99, 32'h0, 0),  4'd8, 3'd0, 3'd0, 0, 0, 1, 1, 32'h10, 32'h11};
    vecs[5] = '{op(2, 32'hAA, 32'hBB, 2), 4'd8, 3'd0, 3'd0, 0, 1, 1, 1, 32'h10, 32'h11};
    vecs[6] = '{op(0, 32'h0, 32'h0, 0),   4'd6, 3'd2, 3'd0, 0, 0, 1, 0, 32'h12, 32'h13};

    // Unchecked first edges bring the DUT out of its unknown power-up state.
    s = idle(); s.rst = 1'b0;
    reset = 0; flush_IN = 0; rollback_IN = 0; rollbackTail_IN = 0; pushCnt_IN = 0;
    data0_IN = 0; data1_IN = 0; popCnt_IN = 0; probeIdx_IN = 0; probeWe_IN = 0;
    probeData_IN = 0;
    repeat (2) @(posedge clk);
    #1;
    model_step(s);

    // Directed table: fill to full, reject overflow, concurrent push/pop at full.
    for (int i = 0; i < 7; i++) begin
      reset = vecs[i].s.rst; flush_IN = vecs[i].s.fl; rollback_IN = vecs[i].s.rb;
      pushCnt_IN = vecs[i].s.pc; data0_IN = vecs[i].s.d0; data1_IN = vecs[i].s.d1;
      popCnt_IN = vecs[i].s.oc; probeWe_IN = vecs[i].s.pwe;
      #1;
      chk($sformatf("vec%0d.count", i), count_OUT, vecs[i].cnt);
      chk($sformatf("vec%0d.head", i), curHead_OUT, vecs[i].h);
      chk($sformatf("vec%0d.tail", i), curTail_OUT, vecs[i].t);
      chk($sformatf("vec%0d.pushAccept", i), pushAccept_OUT, vecs[i].pa);
      chk($sformatf("vec%0d.popAccept", i), popAccept_OUT, vecs[i].oa);
      chk($sformatf("vec%0d.almostFull", i), almostFull_OUT, vecs[i].af);
      chk($sformatf("vec%0d.full", i), fullFlag_OUT, vecs[i].full);
      chk($sformatf("vec%0d.data0", i), data0_OUT, vecs[i].d0);
      chk($sformatf("vec%0d.data1", i), data1_OUT, vecs[i].d1);
      apply(vecs[i].s);
    end

    // Wrap-around and rejected over-pop.
    do_reset();
    apply(op(2, 32'h1, 32'h2, 0));
    apply(op(2, 32'h3, 32'h4, 0));
    apply(op(2, 32'h5, 32'h6, 0));
    repeat (3) apply(op(0, 0, 0, 2));
    chk("wrap.head6", curHead_OUT, 3'd6);
    chk("wrap.tail6", curTail_OUT, 3'd6);
    apply(op(2, 32'hA, 32'hB, 0));
    chk("wrap.tail0", curTail_OUT, 3'd0);
    chk("wrap.data0", data0_OUT, 32'hA);
    chk("wrap.data1", data1_OUT, 32'hB);
    apply(op(0, 0, 0, 2));
    chk("wrap.headAfterPop", curHead_OUT, 3'd0);
    chk("wrap.empty", emptyFlag_OUT, 1'b1);
    apply(op(1, 32'hC, 32'h0, 0));
    apply(op(0, 0, 0, 2));
    chk("overpop.count", count_OUT, 4'd1);

    // Rollback: valid shrink, dropped push, invalid target with one-cycle error.
    do_reset();
    apply(op(2, 32'h21, 32'h22, 0));
    apply(op(2, 32'h23, 32'h24, 0));
    apply(op(2, 32'h25, 32'h26, 0));
    apply(op(0, 0, 0, 1));
    chk("rb.preCount", count_OUT, 4'd5);
    s = op(2, 32'h77, 32'h78, 0); s.rb = 1'b1; s.rbt = 3'd3;
    apply(s);
    chk("rb.tail", curTail_OUT, 3'd3);
    chk("rb.count", count_OUT, 4'd2);
    s = idle(); s.rb = 1'b1; s.rbt = 3'd7;
    apply(s);
    chk("rb.errPulse", rollbackErr_OUT, 1'b1);
    chk("rb.tailKept", curTail_OUT, 3'd3);
    apply(idle());
    chk("rb.errCleared", rollbackErr_OUT, 1'b0);

    // Probe write collides with a push to the same slot.
    apply(op(1, 32'h30, 32'h0, 0));
    s = op(1, 32'h31, 32'h0, 0); s.pwe = 1'b1; s.pidx = 3'd4; s.pd = 32'hDEAD;
    reset = 1; pushCnt_IN = 1; probeIdx_IN = 3'd4; #1;
    chk("probe.oldValue", probeData_OUT, 32'h25);
    apply(s);
    chk("probe.wins", probeData_OUT, 32'hDEAD);

    // Flush beats push/pop, then reset in the middle of a push burst.
    s = op(2, 32'h40, 32'h41, 1); s.fl = 1'b1;
    apply(s);
    chk("flush.count", count_OUT, 4'd0);
    chk("flush.head", curHead_OUT, 3'd0);
    chk("flush.tail", curTail_OUT, 3'd0);
    apply(op(2, 32'h50, 32'h51, 0));
    apply(op(2, 32'h52, 32'h53, 0));
    s = op(2, 32'h54, 32'h55, 0); s.rst = 1'b0;
    apply(s);
    chk("midReset.count", count_OUT, 4'd0);
    chk("midReset.empty", emptyFlag_OUT, 1'b1);
    chk("midReset.data0", data0_OUT, 32'h0);
    chk("midReset.valid0", valid0_OUT, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      s.rst  = ($urandom_range(0, 99) != 0);
      s.fl   = ($urandom_range(0, 39) == 0);
      s.rb   = ($urandom_range(0, 9) == 0);
      s.rbt  = 3'($urandom_range(0, 7));
      s.pc   = 2'($urandom_range(0, 3));
      s.oc   = 2'($urandom_range(0, 3));
      s.d0   = $urandom;
      s.d1   = $urandom;
      s.pidx = 3'($urandom_range(0, 7));
      s.pwe  = ($urandom_range(0, 7) == 0);
      s.pd   = $urandom;
      apply(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
